move_ctrl: RTL and testbench
============================

MOVE_CTRL -- requirements
Module: move_ctrl

Interface
REQ-001 SHALL have parameter MAP_WIDTH, default 16, map columns (2..2^COORD_W).
REQ-002 SHALL have parameter MAP_HEIGHT, default 16, map rows (2..2^COORD_W).
REQ-003 SHALL have parameter COORD_W, default 4, coordinate width in bits.
REQ-004 SHALL have parameter WRAP_MODE, default 0; 0 = edges block, 1 = edges wrap to the opposite side.
REQ-005 SHALL have parameter COOLDOWN, default 4, idle cycles enforced after each completed move (0 allowed).
REQ-006 SHALL have parameters INIT_X and INIT_Y, default 0, reset position.
REQ-007 SHALL have port clk  input  1  single clock, rising edge.
REQ-008 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port req_valid  input  1  move request valid.
REQ-010 SHALL have port req_dir  input  4  one-hot direction {right, up, down, left}.
REQ-011 SHALL have port req_ready  output  1  block can accept a request.
REQ-012 SHALL have port obstacle  input  4  neighbour-blocked mask, same bit order as req_dir.
REQ-013 SHALL have port pos_x  output  COORD_W  current column.
REQ-014 SHALL have port pos_y  output  COORD_W  current row.
REQ-015 SHALL have port allow  output  4  currently permitted directions, same bit order.
REQ-016 SHALL have port move_done  output  1  one-cycle pulse when the position updates.
REQ-017 SHALL have port move_reject  output  1  one-cycle pulse when a request is refused.

Function
REQ-018 SHALL implement FSM states IDLE, MOVE, COOL.
REQ-019 SHALL drive req_ready high only in IDLE; a request is accepted when req_valid and req_ready are both high at a clock edge.
REQ-020 SHALL compute allow combinationally from the registered position and obstacle: edge bit = 0 at that boundary when WRAP_MODE=0, edge bit = 1 when WRAP_MODE=1; every bit ANDed with ~obstacle.
REQ-021 SHALL, on acceptance with req_dir one-hot and (req_dir & allow) nonzero, latch the direction and go to MOVE.
REQ-022 SHALL, on acceptance with req_dir not one-hot (zero or multiple bits) or not allowed, pulse move_reject the next cycle and remain in IDLE; position unchanged.
REQ-023 SHALL, in MOVE, update the position by one step in the latched direction at the end of that cycle, pulse move_done in the cycle after, and go to COOL, or to IDLE when COOLDOWN=0.
REQ-024 SHALL, with WRAP_MODE=1, wrap left from 0 to MAP_WIDTH-1, right from MAP_WIDTH-1 to 0, up from 0 to MAP_HEIGHT-1, and down from MAP_HEIGHT-1 to 0; arithmetic uses COORD_W bits, with wrap on map size, not on 2^COORD_W.
REQ-025 SHALL, in COOL, count exactly COOLDOWN cycles, then return to IDLE; requests are not accepted during MOVE or COOL (req_ready low).
REQ-026 SHALL ignore obstacle changes after acceptance; the decision uses values sampled at the accept edge.
REQ-027 SHALL produce a single move_done or move_reject per accepted request, never both, never more than one.
REQ-028 SHALL hold pos_x < MAP_WIDTH and pos_y < MAP_HEIGHT at all times.

Reset
REQ-029 SHALL, on rst_n low, asynchronously force state IDLE, pos_x=INIT_X, pos_y=INIT_Y, move_done=0, move_reject=0, cooldown counter=0.
REQ-030 SHALL discard any in-flight move on reset assertion mid-MOVE or mid-COOL, with no move_done pulse after release.
REQ-031 SHALL assert req_ready in the first cycle after rst_n deasserts.

Structure
REQ-032 SHALL take MAP_WIDTH/MAP_HEIGHT defaults, direction bit indices (LEFT=0, DOWN=1, UP=2, RIGHT=3) and FSM state encodings from the shared game parameter package.
REQ-033 SHALL place the bound/obstacle check in one sub-module, move_allow, parametrised by MAP_WIDTH, MAP_HEIGHT, COORD_W and WRAP_MODE, which is purely combinational.
REQ-034 SHALL size the cooldown counter as $clog2(COOLDOWN+1) bits, minimum 1.

Verification
REQ-035 SHALL cover: reset, then request right with WRAP_MODE=0 -> move_done 2 cycles after accept, pos=(1,0), req_ready low 1+4 cycles.
REQ-036 SHALL cover: at (0,0) with WRAP_MODE=0, request left -> move_reject pulse, pos stays (0,0), req_ready stays high.
REQ-037 SHALL cover: at (0,0) with WRAP_MODE=1, request left -> pos=(15,0); then request up -> pos=(15,15).
REQ-038 SHALL cover: req_dir=4'b0101 or 4'b0000 -> move_reject, no movement; obstacle=4'b1000 with request right -> move_reject.
REQ-039 SHALL cover: back-to-back valid held high with COOLDOWN=4 -> accepts exactly 6 cycles apart; COOLDOWN=0 -> 2 cycles apart.
REQ-040 SHALL cover: rst_n asserted during COOL and during MOVE -> pos=(INIT_X,INIT_Y) immediately, no move_done pulse afterward.

Source files
------------

// File: rtl/move_ctrl_pkg.sv
// Shared game parameters for the grid mover: map defaults, direction bit indices, FSM encodings.
// No latency or backpressure of its own: types, constants and helpers only.
package move_ctrl_pkg;

  localparam int MAP_W_DEF = 16;
  localparam int MAP_H_DEF = 16;

  // Bit positions inside the 4-bit {right, up, down, left} direction vectors
  localparam int DIR_LEFT  = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_RIGHT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_COOL = 2'd2
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/move_allow.sv
// Combinational permitted-direction mask from position, map bounds and the obstacle mask.
// Zero latency, no handshake.
module move_allow
  import move_ctrl_pkg::*;
#(
  parameter int MAP_WIDTH  = MAP_W_DEF,
  parameter int MAP_HEIGHT = MAP_H_DEF,
  parameter int COORD_W    = 4,
  parameter int WRAP_MODE  = 0
) (
  input  logic [COORD_W-1:0] pos_x_i,
  input  logic [COORD_W-1:0] pos_y_i,
  input  logic [3:0]         obstacle_i,
  output logic [3:0]         allow_o
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MAP_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(MAP_HEIGHT - 1);

  logic [3:0] edge_ok;

  always_comb begin
    edge_ok = 4'b1111;
    // With wrapping enabled every edge leads somewhere, so only obstacles block
    if (WRAP_MODE == 0) begin
      edge_ok[DIR_LEFT]  = (pos_x_i != '0);
      edge_ok[DIR_RIGHT] = (pos_x_i != X_MAX);
      edge_ok[DIR_UP]    = (pos_y_i != '0);
      edge_ok[DIR_DOWN]  = (pos_y_i != Y_MAX);
    end
    allow_o = edge_ok & ~obstacle_i;
  end

endmodule

// File: rtl/move_ctrl.sv
// Grid-position mover: accepts one-step move requests, applies them, then enforces a cooldown.
// Move lands 2 cycles after accept; req_ready is low through MOVE and COOLDOWN cycles of COOL.
module move_ctrl
  import move_ctrl_pkg::*;
#(
  parameter int MAP_WIDTH  = MAP_W_DEF,
  parameter int MAP_HEIGHT = MAP_H_DEF,
  parameter int COORD_W    = 4,
  parameter int WRAP_MODE  = 0,
  parameter int COOLDOWN   = 4,
  parameter int INIT_X     = 0,
  parameter int INIT_Y     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  input  logic [3:0]         req_dir,
  output logic               req_ready,
  input  logic [3:0]         obstacle,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [3:0]         allow,
  output logic               move_done,
  output logic               move_reject
);

  localparam int CNT_W      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam int CNT_LAST_I = (COOLDOWN > 0) ? COOLDOWN - 1 : 0;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CNT_LAST_I);
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(MAP_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(MAP_HEIGHT - 1);

  state_e             state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic [3:0]         dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               rej_q, rej_d;
  logic [COORD_W-1:0] step_x, step_y;

  move_allow #(
    .MAP_WIDTH (MAP_WIDTH),
    .MAP_HEIGHT(MAP_HEIGHT),
    .COORD_W   (COORD_W),
    .WRAP_MODE (WRAP_MODE)
  ) u_allow (
    .pos_x_i   (pos_x_q),
    .pos_y_i   (pos_y_q),
    .obstacle_i(obstacle),
    .allow_o   (allow)
  );

  // Wrap targets are the map edges, not the coordinate range; in blocking mode
  // the wrap branches are unreachable because allow already refused the move.
  always_comb begin
    step_x = pos_x_q;
    step_y = pos_y_q;
    if (dir_q[DIR_RIGHT]) begin
      step_x = (pos_x_q == X_MAX) ? '0 : pos_x_q + COORD_W'(1);
    end else if (dir_q[DIR_LEFT]) begin
      step_x = (pos_x_q == '0) ? X_MAX : pos_x_q - COORD_W'(1);
    end else if (dir_q[DIR_UP]) begin
      step_y = (pos_y_q == '0) ? Y_MAX : pos_y_q - COORD_W'(1);
    end else if (dir_q[DIR_DOWN]) begin
      step_y = (pos_y_q == Y_MAX) ? '0 : pos_y_q + COORD_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    rej_d     = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (is_onehot4(req_dir) && ((req_dir & allow) != 4'd0)) begin
            dir_d   = req_dir;
            state_d = ST_MOVE;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ST_MOVE: begin
        pos_x_d = step_x;
        pos_y_d = step_y;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = (COOLDOWN == 0) ? ST_IDLE : ST_COOL;
      end
      ST_COOL: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_x_q <= COORD_W'(INIT_X);
      pos_y_q <= COORD_W'(INIT_Y);
      dir_q   <= 4'd0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign move_done   = done_q;
  assign move_reject = rej_q;

endmodule

// File: tb/tb_move_ctrl.sv
// Bench for move_ctrl: three instances (blocking/cooldown 4, wrapping/cooldown 4, blocking/no cooldown)
// share one stimulus stream and are checked every cycle against a queue-free countdown model.
module tb_move_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid;
  logic [3:0] req_dir;
  logic [3:0] obstacle;
  logic       rdy  [3];
  logic       done [3];
  logic       rej  [3];
  logic [3:0] px   [3];
  logic [3:0] py   [3];
  logic [3:0] alw  [3];

  move_ctrl #(.MAP_WIDTH(16), .MAP_HEIGHT(16), .COORD_W(4), .WRAP_MODE(0),
              .COOLDOWN(4), .INIT_X(0), .INIT_Y(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_dir(req_dir),
    .req_ready(rdy[0]), .obstacle(obstacle), .pos_x(px[0]), .pos_y(py[0]),
    .allow(alw[0]), .move_done(done[0]), .move_reject(rej[0]));

  move_ctrl #(.MAP_WIDTH(16), .MAP_HEIGHT(16), .COORD_W(4), .WRAP_MODE(1),
              .COOLDOWN(4), .INIT_X(0), .INIT_Y(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_dir(req_dir),
    .req_ready(rdy[1]), .obstacle(obstacle), .pos_x(px[1]), .pos_y(py[1]),
    .allow(alw[1]), .move_done(done[1]), .move_reject(rej[1]));

  move_ctrl #(.MAP_WIDTH(16), .MAP_HEIGHT(16), .COORD_W(4), .WRAP_MODE(0),
              .COOLDOWN(0), .INIT_X(5), .INIT_Y(7)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_dir(req_dir),
    .req_ready(rdy[2]), .obstacle(obstacle), .pos_x(px[2]), .pos_y(py[2]),
    .allow(alw[2]), .move_done(done[2]), .move_reject(rej[2]));

  localparam int W = 16;
  localparam int H = 16;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  // Model: position, pending target, edges until the move lands, edges until ready again
  int mx[3], my[3], tx[3], ty[3], acnt[3], rcnt[3];
  bit edone[3], erej[3];

  function automatic int wrap_of(int k); return (k == 1) ? 1 : 0; endfunction
  function automatic int cd_of(int k);   return (k == 2) ? 0 : 4; endfunction
  function automatic int ix_of(int k);   return (k == 2) ? 5 : 0; endfunction
  function automatic int iy_of(int k);   return (k == 2) ? 7 : 0; endfunction

  function automatic logic [3:0] exp_allow(int k, int x, int y, logic [3:0] obs);
    logic [3:0] a;
    a[3] = (wrap_of(k) != 0) || (x < W - 1);
    a[2] = (wrap_of(k) != 0) || (y > 0);
    a[1] = (wrap_of(k) != 0) || (y < H - 1);
    a[0] = (wrap_of(k) != 0) || (x > 0);
    return a & ~obs;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mx[k] = ix_of(k); my[k] = iy_of(k);
      tx[k] = mx[k];    ty[k] = my[k];
      acnt[k] = 0; rcnt[k] = 0;
      edone[k] = 1'b0; erej[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      bit was_ready;
      was_ready = (rcnt[k] == 0);
      edone[k] = 1'b0;
      erej[k]  = 1'b0;
      if (acnt[k] > 0) begin
        acnt[k]--;
        if (acnt[k] == 0) begin
          mx[k] = tx[k]; my[k] = ty[k]; edone[k] = 1'b1;
        end
      end
      if (rcnt[k] > 0) rcnt[k]--;
      if (was_ready && req_valid) begin
        if ($countones(req_dir) == 1 &&
            (req_dir & exp_allow(k, mx[k], my[k], obstacle)) != 4'd0) begin
          tx[k] = mx[k]; ty[k] = my[k];
          if (req_dir[3]) tx[k] = (mx[k] + 1) % W;
          if (req_dir[0]) tx[k] = (mx[k] + W - 1) % W;
          if (req_dir[2]) ty[k] = (my[k] + H - 1) % H;
          if (req_dir[1]) ty[k] = (my[k] + 1) % H;
          acnt[k] = 1;
          rcnt[k] = 1 + cd_of(k);
        end else begin
          erej[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp(string name, int k, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s dut%0d @cyc %0d: got %0d expected %0d", name, k, cyc, act, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      cmp("pos_x", k, int'(px[k]), mx[k]);
      cmp("pos_y", k, int'(py[k]), my[k]);
      cmp("req_ready", k, int'(rdy[k]), (rcnt[k] == 0) ? 1 : 0);
      cmp("allow", k, int'(alw[k]), int'(exp_allow(k, mx[k], my[k], obstacle)));
      cmp("move_done", k, int'(done[k]), int'(edone[k]));
      cmp("move_reject", k, int'(rej[k]), int'(erej[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic [3:0] o);
    req_valid = v;
    req_dir   = d;
    obstacle  = o;
  endtask

  initial begin
    int low0, low2, dat, seen;
    int a0[$];
    int a2[$];

    rst_n = 1'b0;
    drive(1'b0, 4'd0, 4'd0);
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    cmp("rst_pos_x", 0, int'(px[0]), 0);
    cmp("rst_pos_y", 0, int'(py[0]), 0);
    cmp("rst_ready", 0, int'(rdy[0]), 1);
    cmp("rst_init_x", 2, int'(px[2]), 5);
    cmp("rst_init_y", 2, int'(py[2]), 7);

    // Right from (0,0): done 2 cycles after accept, ready low 1+4 cycles
    drive(1'b1, 4'b1000, 4'd0);
    low0 = 0; low2 = 0; dat = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) drive(1'b0, 4'd0, 4'd0);
      if (!rdy[0]) low0++;
      if (!rdy[2]) low2++;
      if (done[0] && dat < 0) dat = i;
    end
    cmp("ready_low_cd4", 0, low0, 5);
    cmp("ready_low_cd0", 2, low2, 1);
    cmp("done_latency", 0, dat, 2);
    cmp("right_pos_x", 0, int'(px[0]), 1);

    drive(1'b1, 4'b0001, 4'd0);
    tick();
    drive(1'b0, 4'd0, 4'd0);
    repeat (7) tick();

    // Left at (0,0): blocked instances reject, wrapping instance lands at column 15
    drive(1'b1, 4'b0001, 4'd0);
    tick();
    cmp("edge_reject", 0, int'(rej[0]), 1);
    cmp("edge_ready", 0, int'(rdy[0]), 1);
    cmp("edge_pos_x", 0, int'(px[0]), 0);
    drive(1'b0, 4'd0, 4'd0);
    repeat (7) tick();
    cmp("wrap_left_x", 1, int'(px[1]), 15);
    cmp("wrap_left_y", 1, int'(py[1]), 0);

    drive(1'b1, 4'b0100, 4'd0);
    tick();
    drive(1'b0, 4'd0, 4'd0);
    repeat (7) tick();
    cmp("wrap_up_x", 1, int'(px[1]), 15);
    cmp("wrap_up_y", 1, int'(py[1]), 15);

    drive(1'b1, 4'b0101, 4'd0);
    tick();
    cmp("multi_hot_rej", 0, int'(rej[0]), 1);
    cmp("multi_hot_rej", 1, int'(rej[1]), 1);
    drive(1'b0, 4'd0, 4'd0);
    repeat (2) tick();

    drive(1'b1, 4'b0000, 4'd0);
    tick();
    cmp("zero_dir_rej", 0, int'(rej[0]), 1);
    drive(1'b0, 4'd0, 4'd0);
    tick();

    drive(1'b1, 4'b1000, 4'b1000);
    tick();
    cmp("obstacle_rej", 0, int'(rej[0]), 1);
    cmp("obstacle_rej", 1, int'(rej[1]), 1);
    drive(1'b0, 4'd0, 4'd0);
    tick();
    cmp("obstacle_pos_x", 0, int'(px[0]), 0);

    // Valid held high: accept spacing equals 2 + cooldown
    drive(1'b1, 4'b1000, 4'd0);
    for (int i = 0; i < 20; i++) begin
      if (rdy[0]) a0.push_back(i);
      if (rdy[2]) a2.push_back(i);
      tick();
    end
    drive(1'b0, 4'd0, 4'd0);
    repeat (8) tick();
    cmp("b2b_count_cd4", 0, (a0.size() >= 3) ? 1 : 0, 1);
    cmp("b2b_count_cd0", 2, (a2.size() >= 3) ? 1 : 0, 1);
    if (a0.size() >= 3) begin
      cmp("b2b_gap_cd4", 0, a0[1] - a0[0], 6);
      cmp("b2b_gap_cd4", 0, a0[2] - a0[1], 6);
    end
    if (a2.size() >= 3) begin
      cmp("b2b_gap_cd0", 2, a2[1] - a2[0], 2);
      cmp("b2b_gap_cd0", 2, a2[2] - a2[1], 2);
    end

    // Reset during MOVE, then during COOL
    for (int r = 0; r < 2; r++) begin
      drive(1'b1, 4'b1000, 4'd0);
      tick();
      drive(1'b0, 4'd0, 4'd0);
      if (r == 1) repeat (2) tick();
      rst_n = 1'b0;
      model_reset();
      #1;
      cmp("midreset_pos_x", 0, int'(px[0]), 0);
      cmp("midreset_pos_y", 0, int'(py[0]), 0);
      cmp("midreset_pos_x", 2, int'(px[2]), 5);
      tick();
      rst_n = 1'b1;
      seen = 0;
      repeat (6) begin
        tick();
        if (done[0]) seen++;
      end
      cmp("no_done_after_reset", 0, seen, 0);
    end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end else begin
        logic [3:0] d, o;
        if ($urandom_range(0, 9) < 8) d = 4'(1 << $urandom_range(0, 3));
        else d = 4'($urandom_range(0, 15));
        o = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        drive($urandom_range(0, 3) != 0, d, o);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
